// File: rtl/hazard_if.sv
// hazard_if: the hazard controller's link to the pipeline.
//   master: the pipeline side. It drives the decode/EX/MEM/WB status and
//           redirect, and receives the enables, flush/bubble controls,
//           forwarding selects and performance counters.
//   slave : hazard_ctrl.
interface hazard_if;
    logic        de_valid;
    logic [4:0]  de_rs1;
    logic [4:0]  de_rs2;
    logic        de_use_rs1;
    logic        de_use_rs2;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic        redirect;
    logic        fe_en;
    logic        de_en;
    logic        ex_bubble;
    logic        flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        output de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2,
               ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_rs1, ex_rs2,
               mem_valid, mem_reg_write, mem_rd,
               wb_valid, wb_reg_write, wb_rd, redirect,
        input  fe_en, de_en, ex_bubble, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2,
               ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_rs1, ex_rs2,
               mem_valid, mem_reg_write, mem_rd,
               wb_valid, wb_reg_write, wb_rd, redirect,
        output fe_en, de_en, ex_bubble, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RV32 core.
// It produces the fetch/decode enables, the EX bubble and the flush. It also
// produces the EX operand-forwarding selects, and keeps saturating stall and
// flush counters.
// Ports:
//   clk_i   - core clock
//   reset_i - synchronous, active-high reset
//   bus     - hazard_if.slave (stage status and redirect in; controls and
//             counters out)
// Parameter FLUSH_CYCLES (1..4): the number of flush cycles per redirect.
// Build option HAZARD_FORWARDING_EN: when defined, the forwarding selects are
// live, and only load-use and decode-vs-WB hazards stall. When undefined, the
// selects are tied to 00, and any RAW hazard against EX/MEM/WB stalls.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic     clk_i,
    input  logic     reset_i,
    hazard_if.slave  bus
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;
    localparam logic [1:0] CNT_RELOAD = 2'(FLUSH_CYCLES - 1);

    // A stage matches source s when it writes a non-zero rd equal to s.
    function automatic logic hit(input logic v, input logic we,
                                 input logic [4:0] rd, input logic [4:0] s);
        return v & we & (rd == s) & (rd != 5'd0);
    endfunction

    logic [0:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    logic use1, use2;
    logic ex_hit, wb_hit, hz;
    logic flush_int, stall;
    logic [1:0] fwd_a_int, fwd_b_int;

    assign use1 = bus.de_valid & bus.de_use_rs1;
    assign use2 = bus.de_valid & bus.de_use_rs2;

    assign ex_hit = (use1 & hit(bus.ex_valid, bus.ex_reg_write, bus.ex_rd, bus.de_rs1))
                  | (use2 & hit(bus.ex_valid, bus.ex_reg_write, bus.ex_rd, bus.de_rs2));
    assign wb_hit = (use1 & hit(bus.wb_valid, bus.wb_reg_write, bus.wb_rd, bus.de_rs1))
                  | (use2 & hit(bus.wb_valid, bus.wb_reg_write, bus.wb_rd, bus.de_rs2));

`ifdef HAZARD_FORWARDING_EN
    // EX results can be forwarded, except load data, which is not ready yet.
    // WB must still stall, because the register file has no write-through.
    assign hz = (ex_hit & bus.ex_mem_read) | wb_hit;

    // MEM holds the younger value, so it wins over WB.
    assign fwd_a_int = hit(bus.mem_valid, bus.mem_reg_write, bus.mem_rd, bus.ex_rs1) ? 2'b01 :
                       hit(bus.wb_valid,  bus.wb_reg_write,  bus.wb_rd,  bus.ex_rs1) ? 2'b10 :
                                                                                       2'b00;
    assign fwd_b_int = hit(bus.mem_valid, bus.mem_reg_write, bus.mem_rd, bus.ex_rs2) ? 2'b01 :
                       hit(bus.wb_valid,  bus.wb_reg_write,  bus.wb_rd,  bus.ex_rs2) ? 2'b10 :
                                                                                       2'b00;
`else
    logic mem_hit;
    logic unused_fwd;

    assign mem_hit = (use1 & hit(bus.mem_valid, bus.mem_reg_write, bus.mem_rd, bus.de_rs1))
                   | (use2 & hit(bus.mem_valid, bus.mem_reg_write, bus.mem_rd, bus.de_rs2));
    assign hz         = ex_hit | mem_hit | wb_hit;
    assign fwd_a_int  = 2'b00;
    assign fwd_b_int  = 2'b00;
    assign unused_fwd = ^{bus.ex_mem_read, bus.ex_rs1, bus.ex_rs2};
`endif

    // A redirect kills the younger instructions, so any stall they caused is moot.
    assign flush_int = bus.redirect | (state_q == FLUSH);
    assign stall     = hz & ~flush_int;

    assign bus.fe_en     = ~reset_i & ~stall;
    assign bus.de_en     = ~reset_i & ~stall;
    assign bus.ex_bubble = reset_i | stall | flush_int;
    assign bus.flush     = reset_i | flush_int;
    assign bus.fwd_a     = reset_i ? 2'b00 : fwd_a_int;
    assign bus.fwd_b     = reset_i ? 2'b00 : fwd_b_int;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

    // The redirect cycle itself is the first flush cycle. FLUSH therefore
    // covers the remaining FLUSH_CYCLES-1 cycles, and is skipped entirely
    // when FLUSH_CYCLES is 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (bus.redirect && FLUSH_CYCLES > 1) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_RELOAD;
                end
            end
            default: begin
                if (bus.redirect) begin
                    cnt_d = CNT_RELOAD;
                end else if (cnt_q == 2'd1) begin
                    state_d = RUN;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
        endcase
    end

    // The counters saturate rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
        if (flush_int && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= RUN;
            cnt_q       <= 2'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test for hazard_ctrl.
// u2 is built with FLUSH_CYCLES=2 and u3 with FLUSH_CYCLES=3. Both share the
// same stimulus. The hazard section matches the HAZARD_FORWARDING_EN build.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_if h2 ();
    hazard_if h3 ();

    assign h3.de_valid      = h2.de_valid;
    assign h3.de_rs1        = h2.de_rs1;
    assign h3.de_rs2        = h2.de_rs2;
    assign h3.de_use_rs1    = h2.de_use_rs1;
    assign h3.de_use_rs2    = h2.de_use_rs2;
    assign h3.ex_valid      = h2.ex_valid;
    assign h3.ex_reg_write  = h2.ex_reg_write;
    assign h3.ex_mem_read   = h2.ex_mem_read;
    assign h3.ex_rd         = h2.ex_rd;
    assign h3.ex_rs1        = h2.ex_rs1;
    assign h3.ex_rs2        = h2.ex_rs2;
    assign h3.mem_valid     = h2.mem_valid;
    assign h3.mem_reg_write = h2.mem_reg_write;
    assign h3.mem_rd        = h2.mem_rd;
    assign h3.wb_valid      = h2.wb_valid;
    assign h3.wb_reg_write  = h2.wb_reg_write;
    assign h3.wb_rd         = h2.wb_rd;
    assign h3.redirect      = h2.redirect;

    hazard_ctrl #(.FLUSH_CYCLES(2)) u2 (.clk_i(clk), .reset_i(rst), .bus(h2));
    hazard_ctrl #(.FLUSH_CYCLES(3)) u3 (.clk_i(clk), .reset_i(rst), .bus(h3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        h2.de_valid = 0; h2.de_rs1 = 0; h2.de_rs2 = 0; h2.de_use_rs1 = 0; h2.de_use_rs2 = 0;
        h2.ex_valid = 0; h2.ex_reg_write = 0; h2.ex_mem_read = 0;
        h2.ex_rd = 0; h2.ex_rs1 = 0; h2.ex_rs2 = 0;
        h2.mem_valid = 0; h2.mem_reg_write = 0; h2.mem_rd = 0;
        h2.wb_valid = 0; h2.wb_reg_write = 0; h2.wb_rd = 0;
        h2.redirect = 0;
    endtask

    initial begin
        // Reset for 2 cycles, with redirect high.
        idle();
        rst = 1; h2.redirect = 1;
        #1;
        chk("rst_flush", h2.flush, 1);
        chk("rst_fe_en", h2.fe_en, 0);
        chk("rst_de_en", h2.de_en, 0);
        chk("rst_bubble", h2.ex_bubble, 1);
        tick(); tick();
        chk("rst_stall_cnt", h2.stall_cnt, 0);
        chk("rst_flush_cnt", h2.flush_cnt, 0);
        rst = 0; h2.redirect = 0;
        #1;
        chk("rel_fe_en", h2.fe_en, 1);
        chk("rel_flush", h2.flush, 0);
        chk("rel_bubble", h2.ex_bubble, 0);
        chk("rel_flush_u3", h3.flush, 0);

        // Single redirect, with a load-use hazard at t+1 that must be ignored.
        h2.redirect = 1; #1;
        chk("rd_t_u2", h2.flush, 1);
        chk("rd_t_u3", h3.flush, 1);
        tick();
        h2.redirect = 0;
        h2.de_valid = 1; h2.de_rs1 = 5; h2.de_use_rs1 = 1;
        h2.ex_valid = 1; h2.ex_reg_write = 1; h2.ex_mem_read = 1; h2.ex_rd = 5;
        #1;
        chk("rd_t1_flush", h2.flush, 1);
        chk("rd_t1_fe_en", h2.fe_en, 1);
        chk("rd_t1_bubble", h2.ex_bubble, 1);
        tick();
        idle(); #1;
        chk("rd_t2_u2", h2.flush, 0);
        chk("rd_t2_u3", h3.flush, 1);
        tick();
        chk("rd_t3_u3", h3.flush, 0);
        chk("rd_fcnt_u2", h2.flush_cnt, 2);
        chk("rd_fcnt_u3", h3.flush_cnt, 3);
        chk("rd_scnt_u2", h2.stall_cnt, 0);

        // Back-to-back redirects at t and t+1.
        h2.redirect = 1; tick();
        #1; chk("b2b_t1_u3", h3.flush, 1);
        tick();
        h2.redirect = 0; #1;
        chk("b2b_t2_u3", h3.flush, 1);
        chk("b2b_t2_u2", h2.flush, 1);
        tick();
        chk("b2b_t3_u3", h3.flush, 1);
        chk("b2b_t3_u2", h2.flush, 0);
        tick();
        chk("b2b_t4_u3", h3.flush, 0);
        chk("b2b_fcnt_u3", h3.flush_cnt, 7);
        chk("b2b_fcnt_u2", h2.flush_cnt, 5);

`ifdef HAZARD_FORWARDING_EN
        // Load-use: EX lw x5, and decode add x6,x5,x1.
        h2.ex_valid = 1; h2.ex_reg_write = 1; h2.ex_mem_read = 1; h2.ex_rd = 5;
        h2.de_valid = 1; h2.de_rs1 = 5; h2.de_rs2 = 1; h2.de_use_rs1 = 1; h2.de_use_rs2 = 1;
        #1;
        chk("lu_fe_en", h2.fe_en, 0);
        chk("lu_de_en", h2.de_en, 0);
        chk("lu_bubble", h2.ex_bubble, 1);
        tick();
        chk("lu_scnt", h2.stall_cnt, 1);
        h2.ex_valid = 0; #1;
        chk("lu_next_fe_en", h2.fe_en, 1);
        tick();
        // A non-load EX writer is forwarded, so there is no stall.
        h2.ex_valid = 1; h2.ex_mem_read = 0; #1;
        chk("ex_fwd_nostall", h2.fe_en, 1);
        // The x0 destination never matches.
        h2.ex_mem_read = 1; h2.ex_rd = 0; h2.de_rs1 = 0; #1;
        chk("x0_nostall", h2.fe_en, 1);
        h2.ex_valid = 0;
        // A decode-vs-WB match stalls (no write-through).
        h2.wb_valid = 1; h2.wb_reg_write = 1; h2.wb_rd = 1; #1;
        chk("wb_stall", h2.fe_en, 0);
        tick();
        chk("wb_scnt", h2.stall_cnt, 2);
        idle();
        // Forwarding selects.
        h2.mem_valid = 1; h2.mem_reg_write = 1; h2.mem_rd = 5;
        h2.wb_valid = 1; h2.wb_reg_write = 1; h2.wb_rd = 5; h2.ex_rs1 = 5; #1;
        chk("fwd_a_mem_prio", h2.fwd_a, 2'b01);
        h2.wb_rd = 7; h2.ex_rs2 = 7; #1;
        chk("fwd_b_wb", h2.fwd_b, 2'b10);
        h2.mem_valid = 0; h2.wb_rd = 5; #1;
        chk("fwd_a_wb", h2.fwd_a, 2'b10);
        h2.mem_valid = 1; h2.mem_rd = 0; h2.wb_rd = 0; h2.ex_rs1 = 0; #1;
        chk("fwd_a_x0", h2.fwd_a, 2'b00);
        tick();
        chk("fwd_scnt", h2.stall_cnt, 2);
`else
        // Without forwarding, EX add x5 followed by a read of x5 stalls 3 cycles.
        h2.ex_valid = 1; h2.ex_reg_write = 1; h2.ex_rd = 5;
        h2.de_valid = 1; h2.de_rs1 = 5; h2.de_rs2 = 1; h2.de_use_rs1 = 1; h2.de_use_rs2 = 1;
        #1;
        chk("nf_c1_fe_en", h2.fe_en, 0);
        chk("nf_c1_de_en", h2.de_en, 0);
        chk("nf_c1_bubble", h2.ex_bubble, 1);
        chk("nf_c1_fwd_a", h2.fwd_a, 0);
        tick();
        h2.ex_valid = 0; h2.mem_valid = 1; h2.mem_reg_write = 1; h2.mem_rd = 5;
        h2.ex_rs1 = 5; h2.ex_rs2 = 5; #1;
        chk("nf_c2_fe_en", h2.fe_en, 0);
        chk("nf_c2_fwd_a", h2.fwd_a, 0);
        chk("nf_c2_fwd_b", h2.fwd_b, 0);
        tick();
        h2.mem_valid = 0; h2.wb_valid = 1; h2.wb_reg_write = 1; h2.wb_rd = 5; #1;
        chk("nf_c3_fe_en", h2.fe_en, 0);
        chk("nf_c3_fwd_a", h2.fwd_a, 0);
        tick();
        h2.wb_valid = 0; #1;
        chk("nf_c4_fe_en", h2.fe_en, 1);
        chk("nf_scnt", h2.stall_cnt, 3);
        tick();
        // The x0 destination never matches.
        h2.ex_valid = 1; h2.ex_rd = 0; h2.de_rs1 = 0; #1;
        chk("nf_x0", h2.fe_en, 1);
        // Sources the instruction does not read do not stall.
        h2.ex_rd = 5; h2.de_rs1 = 5; h2.de_use_rs1 = 0; #1;
        chk("nf_nouse", h2.fe_en, 1);
        // An invalid decode does not stall.
        h2.de_use_rs1 = 1; h2.de_valid = 0; #1;
        chk("nf_devalid", h2.fe_en, 1);
        tick();
        chk("nf_scnt2", h2.stall_cnt, 3);
        idle();
`endif

        // Reset in the middle of a flush aborts the flush.
        idle();
        h2.redirect = 1; tick();
        h2.redirect = 0; rst = 1; #1;
        chk("mid_rst_flush", h3.flush, 1);
        tick();
        rst = 0; #1;
        chk("post_rst_flush_u3", h3.flush, 0);
        chk("post_rst_fcnt_u3", h3.flush_cnt, 0);
        chk("post_rst_scnt_u2", h2.stall_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32 core. It watches decode-stage source registers and the EX/MEM/WB destination registers, plus the EX-stage redirect. From these it produces the fetch/decode enables, the bubble and flush controls, and the EX operand-forwarding selects. It sits beside `decode`: it drives decode's `en` and `pc_r` and the `v_de` kill. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: number of cycles `flush` stays high per redirect. Legal range 1..4.

Ports:
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `de_valid` in 1: decode holds a valid instruction.
- `de_rs1`, `de_rs2` in 5: decode source register indices.
- `de_use_rs1`, `de_use_rs2` in 1: the instruction actually reads that source.
- `ex_valid`, `ex_reg_write`, `ex_mem_read` in 1: EX-stage status.
- `ex_rd`, `ex_rs1`, `ex_rs2` in 5: EX-stage register indices.
- `mem_valid`, `mem_reg_write` in 1; `mem_rd` in 5: MEM-stage writer.
- `wb_valid`, `wb_reg_write` in 1; `wb_rd` in 5: WB-stage writer.
- `redirect` in 1: EX resolved a taken branch or jump this cycle.
- `fe_en` out 1: fetch advances.
- `de_en` out 1: decode register loads.
- `ex_bubble` out 1: decode-to-EX register loads with `v_de=0`.
- `flush` out 1: kills the fetch/decode contents; drives `pc_r`.
- `fwd_a`, `fwd_b` out 2: EX operand select. 00 = register file, 01 = MEM result, 10 = WB result.
- `stall_cnt`, `flush_cnt` out 32: performance counters.

## Operation
- Match rule: a stage matches a source `s` when its valid and reg_write are both high, its rd equals `s`, and rd is not 0. x0 never matches.
- A decode operand counts only when `de_valid` and the corresponding `de_use_rsN` are high.
- Hazard with `FORWARDING_EN` defined:
  - `hz` = a decode operand matches EX and `ex_mem_read` is high (load-use), or
  - a decode operand matches WB (register file has no write-through).
- Hazard without `FORWARDING_EN`: `hz` = a decode operand matches EX, MEM or WB.
- FSM states:
  - RUN: if `redirect`, go to FLUSH with `cnt = FLUSH_CYCLES-1`. If `FLUSH_CYCLES==1`, stay in RUN. Otherwise stay in RUN.
  - FLUSH: `redirect` reloads `cnt = FLUSH_CYCLES-1`. Otherwise, if `cnt==1`, go to RUN; else decrement `cnt`.
- Outputs (combinational):
  - `flush = redirect | (state==FLUSH)`.
  - `stall = hz & ~flush`, so flush beats stall.
  - `fe_en = de_en = ~stall`.
  - `ex_bubble = stall | flush`.
- Forwarding for `fwd_a`, with `ex_rs1` as source (`fwd_b` is identical using `ex_rs2`):
  - 01 if MEM matches.
  - Else 10 if WB matches.
  - Else 00.
  - MEM has priority over WB.
- Counters:
  - `stall_cnt` increments on every cycle `stall` is high.
  - `flush_cnt` increments on every cycle `flush` is high.
  - Both saturate at 32'hFFFF_FFFF and never wrap.

## Timing
- The FSM and counters update on the rising edge of `clk`. All control outputs are combinational on current inputs and state, so they take effect in the same cycle.
- A load-use stall lasts exactly 1 cycle, because the bubble clears EX on the next edge.
- Without forwarding, a RAW on the instruction directly ahead stalls 3 cycles, until the writer leaves WB.
- A redirect produces exactly `FLUSH_CYCLES` consecutive `flush` cycles, starting in the redirect cycle.
- A redirect during FLUSH restarts the window from that cycle.
- While `reset` is high:
  - Outputs are forced: `fe_en=0`, `de_en=0`, `ex_bubble=1`, `flush=1`, `fwd_a=fwd_b=0`.
  - At the edge: `state=RUN`, `cnt=0`, both counters cleared to 0. Counters do not count during reset.
- Reset asserted mid-FLUSH aborts the flush; the first post-reset cycle is RUN.

## Configuration
- `HAZARD_FORWARDING_EN` defined:
  - Forwarding selects are live.
  - Only load-use and decode-vs-WB hazards stall.
- Not defined:
  - `fwd_a` and `fwd_b` are tied to 00.
  - Any RAW hazard against EX, MEM or WB stalls.
- The `FORWARDING_EN` mentioned above refers to this macro.

## Test plan
- Reset: hold `reset` 2 cycles with `redirect=1` → `flush=1`, `fe_en=0`, counters 0. On release with no hazards → `fe_en=1`, `flush=0`.
- Load-use (forwarding on): EX is `lw x5` (`ex_mem_read=1`), decode is `add x6,x5,x1` → one cycle with `fe_en=0` and `ex_bubble=1`, `stall_cnt=1`. Next cycle (`ex_valid=0`) → `fe_en=1`.
- Forwarding: `mem_rd=5`, `wb_rd=5`, both writing, `ex_rs1=5` → `fwd_a=01`. `ex_rs2=7`, `wb_rd=7` only → `fwd_b=10`. Repeat with `mem_rd=0` and `ex_rs1=0` → `fwd_a=00`.
- Redirect (`FLUSH_CYCLES=2`): pulse at cycle t → `flush` high at t and t+1, low at t+2, `flush_cnt=2`. A load-use hazard at t+1 is ignored and `stall_cnt` is unchanged.
- Back-to-back redirects at t and t+1 (`FLUSH_CYCLES=3`) → `flush` high t..t+3, `flush_cnt=4`.
- No forwarding: EX is `add x5`, decode reads x5 → `stall` high 3 cycles, `stall_cnt=3`, `fwd_a=fwd_b=00` throughout.
